uart_frame_rx: RTL
==================

# uart_frame_rx

Byte-stream deframer placed directly downstream of `uart_top`'s receive port. It consumes received bytes through a ready/valid handshake and hunts for a sync byte. Each complete frame is buffered internally and, only if the frame is valid, replayed to the consumer as a payload burst with a last-byte marker. Malformed, corrupted or stalled frames are dropped, and an error pulse with a cause code is raised.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes (1..255); sizes the internal buffer.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, 50000: idle clocks allowed between bytes inside a frame.

- `clk` in 1: single clock; all state is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: received byte; wired to `uart_top.rx_data`.
- `in_valid` in 1: byte present; wired to `rx_valid`.
- `in_ready` out 1: byte accepted when high together with `in_valid`; wired to `rx_ready`.
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: marks the final payload byte of the frame.
- `out_ready` in 1: consumer accepts the byte.
- `frame_ok` out 1: one-cycle pulse when a valid frame begins draining.
- `frame_err` out 1: one-cycle pulse when a frame is dropped.
- `err_code` out 2: cause of the last drop (1 = bad length, 2 = checksum, 3 = timeout); holds until the next error.

## Operation
- Frame format: `SYNC_BYTE`, `LEN`, `LEN` payload bytes, `CSUM`.
  - `CSUM` makes the sum (LEN + payload + CSUM) mod 256 equal 0.
  - The sync byte is excluded from the sum.
- States and transitions:
  - HUNT: bytes other than `SYNC_BYTE` are discarded silently. `SYNC_BYTE` moves to LEN.
  - LEN: LEN = 0 or LEN > `MAX_LEN` causes a drop with code 1, then HUNT. The offending byte is not re-examined as a sync byte. Otherwise store the length, seed the running sum with LEN and go to PAYLOAD.
  - PAYLOAD: write each byte to buffer[idx], add it to the 8-bit running sum (wrap-around), and increment idx. After byte LEN, go to CSUM.
  - CSUM: if (sum + byte) mod 256 == 0, go to DRAIN. Otherwise drop with code 2 and go to HUNT.
  - DRAIN: replay buffer[0..LEN-1] on `out_*`. On the handshake of the last byte, return to HUNT.
- `in_ready` is 1 in HUNT, LEN, PAYLOAD and CSUM, and 0 in DRAIN. This backpressures the UART; bytes arriving during DRAIN remain `uart_top`'s responsibility.
- Timeout:
  - The counter clears on every accepted byte.
  - It increments each cycle spent in LEN, PAYLOAD or CSUM without an accept.
  - On reaching `TIMEOUT_CLKS`, the frame is dropped with code 3 and the state returns to HUNT.
  - The counter does not run in HUNT or DRAIN.
- A drop never produces `out_valid`. A partially written buffer is simply overwritten by the next frame.

## Timing
- Reset values: `in_ready`=1 (HUNT), `out_valid`=0, `out_last`=0, `out_data`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0, state HUNT, counters 0.
- A reset asserted mid-frame or mid-drain aborts immediately. No pulse is emitted.
- Final frame byte accepted at edge N:
  - State is DRAIN from cycle N+1.
  - `out_valid` is 1 and `frame_ok` is 1 for that single cycle.
  - `out_data` is buffer[0] in cycle N+1.
- One byte is transferred per cycle while `out_ready`=1. A full drain takes LEN cycles minimum.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- `frame_err` and the updated `err_code` are registered: they appear in the cycle after the offending byte is accepted, or the cycle after the timeout count is reached.
- The next frame's sync byte can be accepted in the cycle after the last drain handshake.

## Configuration
- `UART_FRAME_CSUM_EN` defined:
  - The CSUM byte and state exist as described above.
  - Error code 2 is possible.
- `UART_FRAME_CSUM_EN` undefined:
  - Frames are `SYNC_BYTE`, `LEN`, payload only.
  - DRAIN is entered directly after payload byte LEN, with the same N+1 timing.
  - No running sum is implemented, and `err_code` never takes the value 2.

## Test plan
- Valid frame: A5 03 11 22 33 97 with `out_ready`=1 -> out 11, 22, 33 on consecutive cycles. `out_last` is asserted only on 33, `frame_ok` pulses once, and `frame_err` stays 0.
- Bad checksum: A5 03 11 22 33 00 -> no `out_valid`; `frame_err` pulses with `err_code`=2. A following valid frame drains normally.
- Bad length (`MAX_LEN`=16): A5 00, then A5 11 -> two `frame_err` pulses, both with `err_code`=1, and no output.
- Garbage before sync: 00 FF 5A, then the valid frame from the first scenario -> only 11, 22, 33 are output.
- Backpressure: hold `out_ready`=0 for 20 cycles during DRAIN -> `out_data`=11 stays stable and `in_ready`=0 throughout. Releasing `out_ready` completes the drain unchanged.
- Timeout and reset: A5 02 11, then idle for `TIMEOUT_CLKS` clocks -> `frame_err` with `err_code`=3. Asserting `rst_n`=0 mid-drain -> all outputs return to their reset values.

Source files
------------

// File: rtl/uart_frame_rx_if.sv
// ---------------------------------------------------------------------------
// uart_frame_rx_if
//   Byte-stream bundle around the frame deframer.
//   Upstream side  : in_data / in_valid / in_ready (bytes from the UART)
//   Downstream side: out_data / out_valid / out_last / out_ready (payload)
//   Status         : frame_ok / frame_err pulses, err_code cause of last drop
//
//   slave  modport : the deframer itself
//   master modport : the environment (UART receive port + payload consumer)
// ---------------------------------------------------------------------------
interface uart_frame_rx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last,
               frame_ok, frame_err, err_code
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last,
               frame_ok, frame_err, err_code
    );
endinterface

// File: rtl/uart_frame_rx.sv
// ---------------------------------------------------------------------------
// uart_frame_rx
//   Deframer for the UART receive byte stream. Hunts for SYNC_BYTE, collects
//   LEN payload bytes (and an optional checksum byte) into an internal
//   buffer, then replays the payload as a burst with a last-byte marker.
//   Bad length, bad checksum and inter-byte timeouts drop the frame and
//   raise frame_err with a cause code.
//
//   Frame: SYNC_BYTE, LEN, payload[LEN] (, CSUM when UART_FRAME_CSUM_EN)
//   CSUM makes (LEN + payload + CSUM) mod 256 == 0.
//
//   Build option:
//     UART_FRAME_CSUM_EN - when defined, the CSUM byte is expected and
//                          checked; otherwise frames end after the payload.
//
//   Ports:
//     clk    - single rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - uart_frame_rx_if.slave:
//              in_data/in_valid/in_ready    byte input with backpressure
//              out_data/out_valid/out_last/out_ready payload output
//              frame_ok   pulse when a good frame starts draining
//              frame_err  pulse when a frame is dropped
//              err_code   1=bad length, 2=checksum, 3=timeout (held)
// ---------------------------------------------------------------------------
module uart_frame_rx #(
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_frame_rx_if.slave bus
);
    localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int               TMO_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [1:0]       ERR_LEN   = 2'd1;
    localparam logic [1:0]       ERR_TMO   = 2'd3;
`ifdef UART_FRAME_CSUM_EN
    localparam logic [1:0]       ERR_CSUM  = 2'd2;
`endif

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    state_t state_reg, state_next;

    // Frame bookkeeping
    logic [7:0]       len_reg;
    logic [7:0]       wr_cnt_reg;
    logic [7:0]       rd_cnt_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             frame_ok_reg;
    logic             frame_err_reg;
    logic [1:0]       err_code_reg;

    // Payload buffer (block RAM, registered read, no reset on contents)
    logic [7:0]       buf_mem [MAX_LEN];
    logic [7:0]       rd_data_reg;
    logic             byp_reg;
    logic [7:0]       byp_data_reg;

    // Decode
    logic             in_ready_int;
    logic             accept;
    logic             in_frame_st;
    logic             len_bad;
    logic             last_payload;
    logic             drain_last;
    logic             drain_hs;
    logic             tmo_hit;
    logic             enter_drain;
    logic             drop;
    logic [1:0]       drop_code;
    logic             mem_we;
    logic             rd_en;
    logic [IDX_W-1:0] wr_addr;
    logic [IDX_W-1:0] rd_addr;
    logic             out_valid_int;

`ifdef UART_FRAME_CSUM_EN
    logic [7:0]       sum_reg;
    logic [7:0]       sum_with_byte;
    logic             csum_ok;

    always_comb begin
        sum_with_byte = sum_reg + bus.in_data;
        csum_ok       = (sum_with_byte == 8'd0);
    end

    // Running sum is seeded with LEN and accumulates every payload byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= 8'd0;
        end else if (state_reg == ST_LEN && accept) begin
            sum_reg <= bus.in_data;
        end else if (mem_we) begin
            sum_reg <= sum_with_byte;
        end
    end
`endif

    // -----------------------------------------------------------------
    // Shared decode of the current cycle
    // -----------------------------------------------------------------
    always_comb begin
        in_ready_int = (state_reg != ST_DRAIN);
        accept       = bus.in_valid && in_ready_int;
        in_frame_st  = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) ||
                       (state_reg == ST_CSUM);
        len_bad      = (bus.in_data == 8'd0) || (bus.in_data > MAX_LEN_B);
        last_payload = (wr_cnt_reg == len_reg - 8'd1);
        drain_last   = (rd_cnt_reg == len_reg - 8'd1);
        drain_hs     = (state_reg == ST_DRAIN) && bus.out_ready;
        // Fires on the idle cycle that makes the count reach TIMEOUT_CLKS.
        tmo_hit      = in_frame_st && !accept && (tmo_cnt_reg == TMO_LAST);

        drop      = 1'b0;
        drop_code = ERR_LEN;
        if (tmo_hit) begin
            drop      = 1'b1;
            drop_code = ERR_TMO;
        end else if (state_reg == ST_LEN && accept && len_bad) begin
            drop      = 1'b1;
            drop_code = ERR_LEN;
        end
`ifdef UART_FRAME_CSUM_EN
        else if (state_reg == ST_CSUM && accept && !csum_ok) begin
            drop      = 1'b1;
            drop_code = ERR_CSUM;
        end
`endif
    end

    // -----------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_HUNT: begin
                if (accept && bus.in_data == SYNC_BYTE) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                // A rejected length byte goes back to HUNT without being
                // considered as a new sync byte.
                if (tmo_hit) begin
                    state_next = ST_HUNT;
                end else if (accept) begin
                    state_next = len_bad ? ST_HUNT : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (tmo_hit) begin
                    state_next = ST_HUNT;
                end else if (accept && last_payload) begin
`ifdef UART_FRAME_CSUM_EN
                    state_next = ST_CSUM;
`else
                    state_next = ST_DRAIN;
`endif
                end
            end
            ST_CSUM: begin
`ifdef UART_FRAME_CSUM_EN
                if (tmo_hit) begin
                    state_next = ST_HUNT;
                end else if (accept) begin
                    state_next = csum_ok ? ST_DRAIN : ST_HUNT;
                end
`else
                state_next = ST_HUNT;
`endif
            end
            ST_DRAIN: begin
                if (drain_hs && drain_last) begin
                    state_next = ST_HUNT;
                end
            end
            default: state_next = ST_HUNT;
        endcase
    end

    // -----------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------
    always_comb begin
        out_valid_int  = (state_reg == ST_DRAIN);
        bus.in_ready   = in_ready_int;
        bus.out_valid  = out_valid_int;
        bus.out_last   = out_valid_int && drain_last;
        bus.out_data   = 8'd0;
        if (out_valid_int) begin
            bus.out_data = byp_reg ? byp_data_reg : rd_data_reg;
        end
        bus.frame_ok   = frame_ok_reg;
        bus.frame_err  = frame_err_reg;
        bus.err_code   = err_code_reg;
    end

    // -----------------------------------------------------------------
    // Buffer addressing
    // -----------------------------------------------------------------
    always_comb begin
        enter_drain = (state_next == ST_DRAIN) && (state_reg != ST_DRAIN);
        mem_we      = (state_reg == ST_PAYLOAD) && accept;
        wr_addr     = wr_cnt_reg[IDX_W-1:0];
        // Prefetch: entering DRAIN reads entry 0, each non-final handshake
        // reads the following entry so out_data is ready one cycle later.
        rd_en       = enter_drain || (drain_hs && !drain_last);
        rd_addr     = enter_drain ? '0 : IDX_W'(rd_cnt_reg + 8'd1);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            buf_mem[wr_addr] <= bus.in_data;
        end
        if (rd_en) begin
            rd_data_reg <= buf_mem[rd_addr];
        end
    end

    // -----------------------------------------------------------------
    // Counters, status pulses and read-during-write bypass
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg       <= 8'd0;
            wr_cnt_reg    <= 8'd0;
            rd_cnt_reg    <= 8'd0;
            tmo_cnt_reg   <= '0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= 2'd0;
            byp_reg       <= 1'b0;
            byp_data_reg  <= 8'd0;
        end else begin
            if (state_reg == ST_LEN && accept) begin
                len_reg    <= bus.in_data;
                wr_cnt_reg <= 8'd0;
            end else if (mem_we) begin
                wr_cnt_reg <= wr_cnt_reg + 8'd1;
            end

            if (enter_drain) begin
                rd_cnt_reg <= 8'd0;
            end else if (drain_hs) begin
                rd_cnt_reg <= rd_cnt_reg + 8'd1;
            end

            if (accept || !in_frame_st || tmo_hit) begin
                tmo_cnt_reg <= '0;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end

            frame_ok_reg  <= enter_drain;
            frame_err_reg <= drop;
            if (drop) begin
                err_code_reg <= drop_code;
            end

            // A one-byte frame without a checksum enters DRAIN on the same
            // edge that writes entry 0; the RAM read would see stale data,
            // so capture the incoming byte instead.
            if (rd_en) begin
                byp_reg      <= mem_we && (wr_addr == rd_addr);
                byp_data_reg <= bus.in_data;
            end
        end
    end

endmodule
